// File: rtl/pipeline_hazard_ctrl.sv
// Purpose: stall/flush sequencer for the 5-stage rv32i pipeline, with debug halt/drain and perf counters.
// Latency: stage enables and NOP controls are combinational; counters and halt_ack update one clock later.
// Backpressure: an outstanding imem/dmem access freezes every stage and parks all other events until it clears.
//
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   load_use, br_taken         hazard flag from the forwarding unit, EX redirect
//   imem_read/imem_resp        fetch memory request / response
//   dmem_req/dmem_resp         data memory request / response
//   halt_req, halt_ack         debug halt request (level), drained-and-frozen acknowledge
//   load_pc .. load_mem_wb     PC and stage-register enables
//   squash_if_id, bubble_id_ex NOP insertion into IF/ID and ID/EX
//   pc_redirect                PC mux selects the branch target
//   stall_cnt/flush_cnt/lu_cnt saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int PERF_W     = 32,
  parameter int FLUSH_CYC  = 1,
  parameter int PIPE_DEPTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use,
  input  logic              br_taken,
  input  logic              imem_read,
  input  logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  input  logic              halt_req,
  output logic              halt_ack,
  output logic              load_pc,
  output logic              load_if_id,
  output logic              load_id_ex,
  output logic              load_ex_mem,
  output logic              load_mem_wb,
  output logic              squash_if_id,
  output logic              bubble_id_ex,
  output logic              pc_redirect,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
  output logic [PERF_W-1:0] lu_cnt
);

  localparam int CNT_MAX = (FLUSH_CYC > PIPE_DEPTH) ? FLUSH_CYC : PIPE_DEPTH;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] FLUSH_LEN = CNT_W'(FLUSH_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(PIPE_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu_hold;     // load_use already serviced, waiting for it to drop
  logic             lu_new;
  logic             lu_stall;
  logic             mem_stall;
  logic             stall_inc, flush_inc;

  assign mem_stall = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);
  // A level-held load_use only stalls once; it must drop before it can stall again.
  assign lu_new    = load_use & ~lu_hold;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    squash_if_id = 1'b0;
    bubble_id_ex = 1'b0;
    pc_redirect  = 1'b0;
    lu_stall     = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    if (mem_stall) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      // A halted pipeline is frozen on purpose, not stalled.
      stall_inc   = (state != HALTED);
    end else begin
      unique case (state)
        RUN: begin
          if (br_taken) begin
            pc_redirect  = 1'b1;
            squash_if_id = 1'b1;
            bubble_id_ex = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_CYC > 1) begin
              state_nxt = FLUSH;
              cnt_nxt   = FLUSH_LEN;
            end
          end else if (lu_new) begin
            load_pc      = 1'b0;
            load_if_id   = 1'b0;
            bubble_id_ex = 1'b1;
            lu_stall     = 1'b1;
            stall_inc    = 1'b1;
          end else if (halt_req) begin
            state_nxt = DRAIN;
            cnt_nxt   = DRAIN_LEN;
          end
        end
        FLUSH: begin
          squash_if_id = 1'b1;
          if (br_taken) begin
            pc_redirect  = 1'b1;
            bubble_id_ex = 1'b1;
            flush_inc    = 1'b1;
            cnt_nxt      = FLUSH_LEN;
          end else if (cnt <= CNT_ONE) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        DRAIN: begin
          // Stop fetching and let the older instructions retire behind squashed slots.
          load_pc      = 1'b0;
          squash_if_id = 1'b1;
          if (br_taken) begin
            // Keep the PC architecturally correct for resume after the halt.
            pc_redirect  = 1'b1;
            load_pc      = 1'b1;
            bubble_id_ex = 1'b1;
            flush_inc    = 1'b1;
          end else if (lu_new) begin
            bubble_id_ex = 1'b1;
            load_if_id   = 1'b0;
            lu_stall     = 1'b1;
            stall_inc    = 1'b1;
          end
          if (!halt_req) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end else if (!lu_stall) begin
            if (cnt == CNT_ONE) state_nxt = HALTED;
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        HALTED: begin
          load_pc     = 1'b0;
          load_if_id  = 1'b0;
          load_id_ex  = 1'b0;
          load_ex_mem = 1'b0;
          load_mem_wb = 1'b0;
          if (!halt_req) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end

    if (rst) begin
      load_pc      = 1'b0;
      load_if_id   = 1'b0;
      load_id_ex   = 1'b0;
      load_ex_mem  = 1'b0;
      load_mem_wb  = 1'b0;
      squash_if_id = 1'b0;
      bubble_id_ex = 1'b0;
      pc_redirect  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      lu_hold   <= 1'b0;
      halt_ack  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      lu_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      lu_hold  <= load_use & (lu_hold | lu_stall);
      halt_ack <= (state_nxt == HALTED);
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + PERF_ONE;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + PERF_ONE;
      if (lu_stall  && lu_cnt    != '1) lu_cnt    <= lu_cnt + PERF_ONE;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int M_RUN = 0, M_FLUSH = 1, M_DRAIN = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic rst, load_use, br_taken, imem_read, imem_resp, dmem_req, dmem_resp, halt_req;

  // {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, squash, bubble, redirect}
  wire [7:0]  ctl0, ctl1;
  wire        ack0, ack1;
  wire [31:0] st0, fl0, lu0;
  wire [3:0]  st1, fl1, lu1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut0 (
    .clk(clk), .rst(rst), .load_use(load_use), .br_taken(br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .halt_req(halt_req), .halt_ack(ack0),
    .load_pc(ctl0[7]), .load_if_id(ctl0[6]), .load_id_ex(ctl0[5]), .load_ex_mem(ctl0[4]),
    .load_mem_wb(ctl0[3]), .squash_if_id(ctl0[2]), .bubble_id_ex(ctl0[1]), .pc_redirect(ctl0[0]),
    .stall_cnt(st0), .flush_cnt(fl0), .lu_cnt(lu0)
  );

  pipeline_hazard_ctrl #(.PERF_W(4), .FLUSH_CYC(3), .PIPE_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .load_use(load_use), .br_taken(br_taken),
    .imem_read(imem_read), .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .halt_req(halt_req), .halt_ack(ack1),
    .load_pc(ctl1[7]), .load_if_id(ctl1[6]), .load_id_ex(ctl1[5]), .load_ex_mem(ctl1[4]),
    .load_mem_wb(ctl1[3]), .squash_if_id(ctl1[2]), .bubble_id_ex(ctl1[1]), .pc_redirect(ctl1[0]),
    .stall_cnt(st1), .flush_cnt(fl1), .lu_cnt(lu1)
  );

  int unsigned checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model, one slot per DUT instance.
  int     p_fc [2] = '{1, 3};
  int     p_pd [2] = '{5, 4};
  longint p_mx [2] = '{64'hFFFF_FFFF, 64'd15};

  int       m_mode [2], n_mode [2];
  int       m_left [2], n_left [2];
  bit       m_blk  [2], n_blk  [2];
  bit       m_ack  [2], n_ack  [2];
  longint   m_st [2], m_fl [2], m_lu [2], n_st [2], n_fl [2], n_lu [2];
  logic [7:0] e_ctl [2];

  logic [7:0] last_ctl0;
  int sq0_seen, frz0_seen;

  function automatic longint sat_inc(longint v, longint mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_eval(input int i);
    bit frozen, lu_now, lu_took;
    bit pc, ifid, idex, exmem, memwb, sq, bub, red;
    frozen  = (imem_read && !imem_resp) || (dmem_req && !dmem_resp);
    lu_now  = load_use && !m_blk[i];
    lu_took = 0;
    if (rst) begin
      m_mode[i] = M_RUN; m_left[i] = 0; m_blk[i] = 0; m_ack[i] = 0;
      m_st[i] = 0; m_fl[i] = 0; m_lu[i] = 0;
    end
    n_mode[i] = m_mode[i]; n_left[i] = m_left[i];
    n_st[i] = m_st[i]; n_fl[i] = m_fl[i]; n_lu[i] = m_lu[i];
    {pc, ifid, idex, exmem, memwb} = 5'b11111;
    {sq, bub, red} = 3'b000;
    if (frozen) begin
      {pc, ifid, idex, exmem, memwb} = 5'b00000;
      if (m_mode[i] != M_HALT) n_st[i] = sat_inc(m_st[i], p_mx[i]);
    end else if (m_mode[i] == M_RUN) begin
      if (br_taken) begin
        {sq, bub, red} = 3'b111;
        n_fl[i] = sat_inc(m_fl[i], p_mx[i]);
        if (p_fc[i] > 1) begin n_mode[i] = M_FLUSH; n_left[i] = p_fc[i] - 1; end
      end else if (lu_now) begin
        pc = 0; ifid = 0; bub = 1; lu_took = 1;
        n_lu[i] = sat_inc(m_lu[i], p_mx[i]);
        n_st[i] = sat_inc(m_st[i], p_mx[i]);
      end else if (halt_req) begin
        n_mode[i] = M_DRAIN; n_left[i] = p_pd[i] - 1;
      end
    end else if (m_mode[i] == M_FLUSH) begin
      sq = 1;
      if (br_taken) begin
        red = 1; bub = 1; n_left[i] = p_fc[i] - 1;
        n_fl[i] = sat_inc(m_fl[i], p_mx[i]);
      end else begin
        n_left[i] = m_left[i] - 1;
        if (n_left[i] == 0) n_mode[i] = M_RUN;
      end
    end else if (m_mode[i] == M_DRAIN) begin
      pc = 0; sq = 1;
      if (br_taken) begin
        red = 1; pc = 1; bub = 1;
        n_fl[i] = sat_inc(m_fl[i], p_mx[i]);
      end else if (lu_now) begin
        bub = 1; ifid = 0; lu_took = 1;
        n_lu[i] = sat_inc(m_lu[i], p_mx[i]);
        n_st[i] = sat_inc(m_st[i], p_mx[i]);
      end
      if (!halt_req) begin
        n_mode[i] = M_RUN; n_left[i] = 0;
      end else if (!lu_took) begin
        if (m_left[i] == 1) n_mode[i] = M_HALT;
        n_left[i] = m_left[i] - 1;
      end
    end else begin
      {pc, ifid, idex, exmem, memwb} = 5'b00000;
      if (!halt_req) n_mode[i] = M_RUN;
    end
    n_blk[i] = load_use && (m_blk[i] || lu_took);
    n_ack[i] = (n_mode[i] == M_HALT);
    e_ctl[i] = rst ? 8'h00 : {pc, ifid, idex, exmem, memwb, sq, bub, red};
    if (rst) begin
      n_mode[i] = M_RUN; n_left[i] = 0; n_blk[i] = 0; n_ack[i] = 0;
      n_st[i] = 0; n_fl[i] = 0; n_lu[i] = 0;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 2; i++) model_eval(i);
    chk("ctl0", ctl0, e_ctl[0]);
    chk("ctl1", ctl1, e_ctl[1]);
    chk("ack0", ack0, m_ack[0]);
    chk("ack1", ack1, m_ack[1]);
    chk("stall0", st0, m_st[0]);
    chk("flush0", fl0, m_fl[0]);
    chk("lu0", lu0, m_lu[0]);
    chk("stall1", st1, m_st[1]);
    chk("flush1", fl1, m_fl[1]);
    chk("lu1", lu1, m_lu[1]);
    last_ctl0 = ctl0;
    if (ctl0[2]) sq0_seen++;
    if (ctl0[7:3] == 5'b0) frz0_seen++;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = n_mode[i]; m_left[i] = n_left[i]; m_blk[i] = n_blk[i]; m_ack[i] = n_ack[i];
      m_st[i] = n_st[i]; m_fl[i] = n_fl[i]; m_lu[i] = n_lu[i];
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    {load_use, br_taken, imem_read, imem_resp, dmem_req, dmem_resp, halt_req} = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    chk("rst_ctl0", last_ctl0, 8'h00);
    rst = 1'b0;
    sq0_seen = 0;
    frz0_seen = 0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    do_reset();
    chk("rst_lu0", lu0, 0);
    chk("rst_ack0", ack0, 0);

    // Single load_use pulse.
    load_use = 1; cycle();
    chk("lu_pulse_ctl", last_ctl0, 8'b0011_1010);
    load_use = 0; cycle();
    chk("lu_after_ctl", last_ctl0, 8'b1111_1000);
    chk("lu_pulse_lucnt", lu0, 1);
    chk("lu_pulse_stall", st0, 1);

    // Branch and load_use together: branch wins.
    do_reset();
    br_taken = 1; load_use = 1; cycle();
    chk("br_lu_ctl", last_ctl0, 8'hFF);
    idle_inputs(); cycle();
    chk("br_lu_flush", fl0, 1);
    chk("br_lu_lucnt", lu0, 0);

    // Late data response with a branch waiting behind it.
    do_reset();
    br_taken = 1; dmem_req = 1;
    repeat (3) cycle();
    dmem_resp = 1; cycle();
    chk("dmem_resp_ctl", last_ctl0, 8'hFF);
    idle_inputs(); cycle();
    chk("dmem_frozen", frz0_seen, 3);
    chk("dmem_stall", st0, 3);
    chk("dmem_flush", fl0, 1);

    // Halt / drain / resume.
    do_reset();
    halt_req = 1;
    repeat (5) cycle();
    chk("drain_squash", sq0_seen, 4);
    chk("halt_ack_set", ack0, 1);
    cycle();
    halt_req = 0; cycle();
    chk("halt_ack_clr", ack0, 0);
    cycle();
    chk("resume_ctl", last_ctl0, 8'b1111_1000);

    // Reset in the middle of a drain.
    do_reset();
    halt_req = 1;
    repeat (3) cycle();
    rst = 1; cycle();
    chk("mid_rst_ctl", last_ctl0, 8'h00);
    rst = 0; halt_req = 0; cycle();
    chk("post_rst_ctl", last_ctl0, 8'b1111_1000);
    chk("post_rst_ack", ack0, 0);
    chk("post_rst_stall", st0, 0);

    // Counter saturation on the narrow instance.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      load_use = 1; cycle();
      load_use = 0; cycle();
    end
    chk("sat_lu1", lu1, 15);
    chk("sat_stall1", st1, 15);
    chk("sat_lu0", lu0, 20);

    // Randomized traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      load_use  = ($urandom_range(0, 99) < 20);
      br_taken  = ($urandom_range(0, 99) < 12);
      imem_read = ($urandom_range(0, 99) < 30);
      imem_resp = ($urandom_range(0, 99) < 70);
      dmem_req  = ($urandom_range(0, 99) < 25);
      dmem_resp = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 99) < 6) halt_req = ~halt_req;
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
